lemming_dig_arbiter: RTL

Shares one dig tool between N lemming walker FSMs. Each walker raises a dig request; the arbiter grants the tool to one standing lemming at a time, using round-robin order. It enforces a maximum dig duration and a cooldown gap between grants. It sits between the crew of walker FSMs and their dig inputs: a walker's dig input is its grant bit.

---
 rtl/lemming_dig_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/lemming_dig_arbiter.sv
//==============================================================================
// Module   : lemming_dig_arbiter
// Brief    : Round-robin arbiter that shares one dig tool between N lemming
//            walkers, with a maximum dig duration and a cooldown between
//            grants. Optional macro DIG_STATS_EN adds the dig_total counter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module lemming_dig_arbiter #(
   parameter int N           = 4,
   parameter int MAX_DIG     = 8,
   parameter int COOL_CYCLES = 2,
   localparam int IDW        = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           areset,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   ground,
`ifdef DIG_STATS_EN
   output logic [15:0]    dig_total,
`endif
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] owner_id,
   output logic           busy,
   output logic           timeout
);

   localparam int DCW = $clog2(MAX_DIG) + 1;
   localparam int CCW = $clog2(COOL_CYCLES) + 1;
   localparam logic [DCW-1:0] c_dig_last  = DCW'(MAX_DIG - 1);
   localparam logic [CCW-1:0] c_cool_last = CCW'(COOL_CYCLES - 1);
   localparam logic [IDW-1:0] c_last_idx  = IDW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIG  = 2'd1,
      S_COOL = 2'd2
   } state_t;

   state_t         r_state;
   logic [IDW-1:0] r_rr_ptr;
   logic [DCW-1:0] r_dig_cnt;
   logic [CCW-1:0] r_cool_cnt;

   logic [N-1:0]   w_elig;
   logic           w_found;
   logic [IDW-1:0] w_pick;
   logic [N-1:0]   w_pick_onehot;
   logic [IDW-1:0] w_next_ptr;
   logic           w_owner_ground;
   logic           w_owner_req;

   assign w_elig = req & ground;

   // Scan from the farthest offset down so the nearest eligible index wins.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_elig[IDW'((int'(r_rr_ptr) + k) % N)]) begin
            w_found = 1'b1;
            w_pick  = IDW'((int'(r_rr_ptr) + k) % N);
         end
      end
   end

   assign w_pick_onehot  = {{(N-1){1'b0}}, 1'b1} << w_pick;
   assign w_next_ptr     = (owner_id == c_last_idx) ? '0 : owner_id + 1'b1;
   assign w_owner_ground = ground[owner_id];
   assign w_owner_req    = req[owner_id];

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_state    <= S_IDLE;
         grant      <= '0;
         owner_id   <= '0;
         busy       <= 1'b0;
         timeout    <= 1'b0;
         r_rr_ptr   <= '0;
         r_dig_cnt  <= '0;
         r_cool_cnt <= '0;
      end else begin
         timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  owner_id  <= w_pick;
                  grant     <= w_pick_onehot;
                  busy      <= 1'b1;
                  r_dig_cnt <= '0;
                  r_state   <= S_DIG;
               end
            end
            S_DIG: begin
               // Ground loss and request drop take priority over expiry,
               // so timeout only fires when the owner still wanted the tool.
               if (!w_owner_ground || !w_owner_req || (r_dig_cnt == c_dig_last)) begin
                  timeout    <= w_owner_ground && w_owner_req;
                  grant      <= '0;
                  r_cool_cnt <= '0;
                  r_rr_ptr   <= w_next_ptr;
                  r_state    <= S_COOL;
               end else begin
                  r_dig_cnt <= r_dig_cnt + 1'b1;
               end
            end
            S_COOL: begin
               if (r_cool_cnt == c_cool_last) begin
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cool_cnt <= r_cool_cnt + 1'b1;
               end
            end
            default: begin
               grant   <= '0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef DIG_STATS_EN
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         dig_total <= '0;
      end else if ((grant != '0) && (dig_total != 16'hFFFF)) begin
         dig_total <= dig_total + 16'd1;
      end
   end
`else
   // No statistics counter in this build.
`endif

endmodule

`default_nettype wire
